polar_decode_arbiter: RTL
=========================

Name: polar_decode_arbiter

Overview:
- Round-robin scheduler that shares one decode_block instance among NREQ frame sources, e.g. parallel encode/channel lanes.
- Grants one requester at a time and drives dec_sel so the top level muxes that requester's noisy LLR frame onto decode_block.
- Issues the single-cycle in_valid pulse, waits for decoder out_valid, and returns a per-requester done pulse.
- A watchdog aborts frames the decoder never completes.

Parameters:
- NREQ, 4, number of requesters (2..16)
- TIMEOUT_CYC, 65535, maximum WAIT cycles before abort (must be ≥ 2)
- SELW, $clog2(NREQ), width of dec_sel

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req  in  NREQ  per-requester frame request, level; held until matching done
- gnt  out  NREQ  one-hot grant, high from ISSUE through DONE
- done  out  NREQ  one-cycle completion pulse to granted requester
- err  out  1  qualifies done: 1 = frame aborted by timeout
- dec_in_valid  out  1  single-cycle start pulse to decode_block in_valid
- dec_out_valid  in  1  decode_block out_valid
- dec_sel  out  SELW  index of granted requester, drives the noisy/decoded muxes
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs registered.
- Reset values: state = IDLE, gnt = 0, done = 0, err = 0, dec_in_valid = 0, dec_sel = 0, busy = 0, rr_ptr = 0, wait counter = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req ≠ 0, pick the first set bit scanning rr_ptr, rr_ptr+1, … modulo NREQ.
  - Latch its index into dec_sel, set gnt one-hot, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - dec_in_valid = 1; clear wait counter; go to WAIT.
  - dec_out_valid is ignored in this cycle.
- WAIT:
  - dec_out_valid = 1 → go to DONE with err = 0.
  - Otherwise increment the counter. When counter == TIMEOUT_CYC-1 with no out_valid → go to DONE with err = 1.
  - If out_valid and timeout coincide, out_valid wins (err = 0).
- DONE (1 cycle):
  - done[dec_sel] = 1, err as decided in WAIT, gnt still asserted.
  - rr_ptr ← (dec_sel+1) mod NREQ; next state IDLE, where gnt clears.
- Latency: req seen high at edge k → dec_in_valid high in cycle k+1 → earliest done is cycle k+3 (decoder responding at k+2). Minimum 4 cycles per frame including the IDLE re-arbitration.
- dec_sel is stable from ISSUE until the cycle after DONE; the datapath may sample decoded in DONE.
- req[i] dropped while granted: the frame still completes and done[i] still pulses; the requester ignores it.
- dec_out_valid outside WAIT is ignored and causes no state change.
- Reset asserted mid-frame: immediate return to reset values; the in-flight decode result is discarded. decode_block is not reset by this block.
- Fairness: any continuously asserted req is granted within NREQ grants.

Optional Feature:
- Macro: POLAR_ARB_STATS_EN.
- Defined:
  - Adds outputs frames_ok (32 bits) and frames_to (32 bits), global counters of err = 0 and err = 1 completions.
  - Both increment in the DONE cycle, reset to 0, and saturate at 2^32-1.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- polar_pkg gains:
  - arb_state_t enum {IDLE, ISSUE, WAIT, DONE}.
  - Function rr_pick(req, ptr), returning index plus found flag.
  - Constant POLAR_DEC_TIMEOUT_DEFAULT = 65535.
- One natural sub-module: polar_rr_picker, the combinational rotate/priority-encode/rotate-back used in IDLE. The FSM, counter and stats stay in the top module.

Test Plan:
- Single request: NREQ = 4, req = 0010; stub decoder raises out_valid 5 cycles after in_valid → dec_sel = 1, one in_valid pulse, done = 0010 with err = 0 exactly once, busy = 0 afterwards.
- Round robin: req = 1111 held, each frame acked → grant order 0, 1, 2, 3, 0, 1; no requester granted twice before the others.
- Timeout: TIMEOUT_CYC = 8, stub never answers → done[sel] with err = 1 in the 9th cycle after in_valid; next request is then served normally.
- Coincidence: out_valid arrives on the last timeout cycle → err = 0.
- Spurious and dropped: out_valid pulsed while in IDLE → no state change; req dropped in WAIT → done still pulses.
- Async reset in WAIT:
  - All outputs return to zero without a clock edge; rr_ptr = 0.
  - A later req = 1000 is granted index 3.
- With POLAR_ARB_STATS_EN, after 3 ok frames and 1 timeout → frames_ok = 3, frames_to = 1.
- Full loop with encode_block and decode_block at SNR 10.0 on 2 lanes → 0 bit errors per lane.

Source files
------------

// File: rtl/polar_decode_arbiter_pkg.sv
// Shared types and helpers for the polar decode arbiter.
// Optional statistics outputs are enabled with POLAR_ARB_STATS_EN.
package polar_pkg;

  localparam int unsigned POLAR_DEC_TIMEOUT_DEFAULT = 65535;
  localparam int unsigned RR_MAXREQ                 = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // Width-generic round-robin pick over up to RR_MAXREQ requesters:
  // rotate so ptr lands at bit 0, take the lowest set bit, rotate back.
  function automatic rr_pick_t rr_pick(input logic [RR_MAXREQ-1:0] req,
                                       input logic [3:0]           ptr,
                                       input int unsigned          n);
    logic [RR_MAXREQ-1:0] rot;
    int unsigned          k;
    rr_pick_t             r;
    rot = '0;
    r   = '0;
    for (int unsigned i = 0; i < RR_MAXREQ; i++) begin
      if (i < n) begin
        k = 32'(ptr) + i;
        if (k >= n) k = k - n;
        rot[i] = req[k[3:0]];
      end
    end
    for (int unsigned i = 0; i < RR_MAXREQ; i++) begin
      if (!r.found && rot[i]) begin
        k = 32'(ptr) + i;
        if (k >= n) k = k - n;
        r.found = 1'b1;
        r.idx   = k[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/polar_decode_arbiter_if.sv
// Request/grant/decoder-handshake bundle for polar_decode_arbiter.
// Statistics counters are present only with POLAR_ARB_STATS_EN.
interface polar_decode_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned SELW = $clog2(NREQ)
);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            err;
  logic            dec_in_valid;
  logic            dec_out_valid;
  logic [SELW-1:0] dec_sel;
  logic            busy;
`ifdef POLAR_ARB_STATS_EN
  logic [31:0]     frames_ok;
  logic [31:0]     frames_to;
`endif

  // Arbiter side
  modport master (
    input  req, dec_out_valid,
`ifdef POLAR_ARB_STATS_EN
    output frames_ok, frames_to,
`endif
    output gnt, done, err, dec_in_valid, dec_sel, busy
  );

  // Requesters / decoder side
  modport slave (
    output req, dec_out_valid,
`ifdef POLAR_ARB_STATS_EN
    input  frames_ok, frames_to,
`endif
    input  gnt, done, err, dec_in_valid, dec_sel, busy
  );

endinterface

// File: rtl/polar_decode_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate request vector by ptr,
// priority-encode the lowest set bit, rotate the index back.
module polar_rr_picker
  import polar_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned SELW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic            found_o,
  output logic [SELW-1:0] idx_o
);

  logic [NREQ-1:0] rot;
  logic [SELW:0]   k;

  // Rotate, encode and un-rotate; the extra bit of k absorbs ptr+i before wrap
  always_comb begin
    rot     = '0;
    k       = '0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = {1'b0, ptr_i} + (SELW+1)'(i);
      if (k >= (SELW+1)'(NREQ)) k = k - (SELW+1)'(NREQ);
      rot[i] = req_i[k[SELW-1:0]];
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found_o && rot[i]) begin
        k = {1'b0, ptr_i} + (SELW+1)'(i);
        if (k >= (SELW+1)'(NREQ)) k = k - (SELW+1)'(NREQ);
        found_o = 1'b1;
        idx_o   = k[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/polar_decode_arbiter.sv
// Round-robin scheduler sharing one decode_block among NREQ frame sources.
// Issues a one-cycle in_valid, waits for out_valid (with watchdog abort),
// returns a per-requester done pulse qualified by err.
// Define POLAR_ARB_STATS_EN to add frames_ok/frames_to counters.
module polar_decode_arbiter
  import polar_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = POLAR_DEC_TIMEOUT_DEFAULT,
  parameter int unsigned SELW        = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  polar_decode_arbiter_if.master bus
);

  localparam int unsigned CNTW = $clog2(TIMEOUT_CYC);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;
  logic            div_q, div_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            busy_q, busy_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            pick_found;
  logic [SELW-1:0] pick_idx;

  polar_rr_picker #(
    .NREQ (NREQ),
    .SELW (SELW)
  ) u_picker (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Next-state and next-output decode; outputs are registered from these
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    div_d   = 1'b0;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = ISSUE;
          sel_d   = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          div_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // out_valid takes priority over an expiring watchdog
        if (bus.dec_out_valid) begin
          state_d = DONE;
          done_d  = NREQ'(1) << sel_q;
        end else if (cnt_q == CNTW'(TIMEOUT_CYC - 1)) begin
          state_d = DONE;
          done_d  = NREQ'(1) << sel_q;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = (sel_q == SELW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      div_q   <= 1'b0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.dec_in_valid = div_q;
  assign bus.dec_sel      = sel_q;
  assign bus.busy         = busy_q;

`ifdef POLAR_ARB_STATS_EN
  logic [31:0] ok_q;
  logic [31:0] to_q;

  // Saturating completion counters, bumped during the DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_q <= '0;
      to_q <= '0;
    end else if (state_q == DONE) begin
      if (err_q) begin
        if (to_q != '1) to_q <= to_q + 1'b1;
      end else begin
        if (ok_q != '1) ok_q <= ok_q + 1'b1;
      end
    end
  end

  assign bus.frames_ok = ok_q;
  assign bus.frames_to = to_q;
`endif

endmodule
